// File: rtl/idma_error_responder.sv
// Frontend error responder: passes good 1D responses to the completion stream and
// logs and counts error responses. Each error gets one CONTINUE/ABORT decision on the eh stream.

package idma_pkg;
  typedef enum logic {CONTINUE = 1'b0, ABORT = 1'b1} idma_eh_req_t;
  typedef enum logic [1:0] {
    BUS_READ  = 2'd0,
    BUS_WRITE = 2'd1,
    BACKEND   = 2'd2,
    ND_MIDEND = 2'd3
  } err_type_t;

  localparam int unsigned AddrWidth = 32;
  typedef logic [AddrWidth-1:0] addr_t;

  typedef struct packed {
    logic [1:0] cause;
    err_type_t  err_type;
    addr_t      burst_addr;
  } idma_err_pld_t;

  typedef struct packed {
    logic          last;
    logic          error;
    idma_err_pld_t pld;
  } idma_rsp_t;
endpackage

module idma_error_responder #(
  parameter int unsigned ErrLogDepth   = 4,
  parameter int unsigned ErrCntWidth   = 16,
  parameter bit          PrintFifoInfo = 1'b0,
  parameter type         idma_rsp_t    = idma_pkg::idma_rsp_t,
  parameter type         idma_eh_req_t = idma_pkg::idma_eh_req_t,
  parameter type         addr_t        = idma_pkg::addr_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    testmode_i,
  input  idma_rsp_t               rsp_i,
  input  logic                    rsp_valid_i,
  output logic                    rsp_ready_o,
  output logic                    done_last_o,
  output logic                    done_valid_o,
  input  logic                    done_ready_i,
  output idma_eh_req_t            eh_o,
  output logic                    eh_valid_o,
  input  logic                    eh_ready_i,
  input  logic [1:0]              policy_i,
  input  idma_eh_req_t            sw_eh_i,
  input  logic                    sw_eh_valid_i,
  output logic                    sw_eh_ready_o,
  output addr_t                   log_addr_o,
  output logic [1:0]              log_cause_o,
  output idma_pkg::err_type_t     log_type_o,
  output logic                    log_valid_o,
  input  logic                    log_pop_i,
  output logic                    log_ovf_o,
  input  logic                    log_ovf_clr_i,
  output logic [ErrCntWidth-1:0]  err_cnt_o,
  output logic                    irq_o,
  output logic                    busy_o
);

  localparam int unsigned PtrW = (ErrLogDepth > 1) ? $clog2(ErrLogDepth) : 1;
  localparam int unsigned CntW = $clog2(ErrLogDepth + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(ErrLogDepth);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SW = 2'd1, ISSUE = 2'd2} state_e;

  state_e                   state_q, state_d;
  idma_eh_req_t             eh_q, eh_d;
  logic                     err_acc;

  addr_t                    addr_mem_q  [ErrLogDepth];
  addr_t                    addr_mem_d  [ErrLogDepth];
  logic [1:0]               cause_mem_q [ErrLogDepth];
  logic [1:0]               cause_mem_d [ErrLogDepth];
  idma_pkg::err_type_t      type_mem_q  [ErrLogDepth];
  idma_pkg::err_type_t      type_mem_d  [ErrLogDepth];
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic [ErrCntWidth-1:0]   err_cnt_q, err_cnt_d;
  logic                     pop_eff, push_ok, push_drop;

  // Test mode and the print switch have no function in this FIFO implementation.
  logic unused_cfg;
  assign unused_cfg = testmode_i ^ PrintFifoInfo;

  // Handshake steering and next-state decode.
  always_comb begin
    state_d       = state_q;
    eh_d          = eh_q;
    rsp_ready_o   = 1'b0;
    done_valid_o  = 1'b0;
    done_last_o   = 1'b0;
    sw_eh_ready_o = 1'b0;
    err_acc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rsp_i.error) begin
          rsp_ready_o = 1'b1;
          if (rsp_valid_i) begin
            err_acc = 1'b1;
            unique case (policy_i)
              2'b01: begin
                eh_d    = idma_eh_req_t'(idma_pkg::CONTINUE);
                state_d = ISSUE;
              end
              2'b10: begin
                eh_d    = idma_eh_req_t'(idma_pkg::ABORT);
                state_d = ISSUE;
              end
              default: state_d = WAIT_SW;
            endcase
          end
        end else begin
          done_valid_o = rsp_valid_i;
          done_last_o  = rsp_valid_i & rsp_i.last;
          rsp_ready_o  = done_ready_i;
        end
      end
      WAIT_SW: begin
        sw_eh_ready_o = 1'b1;
        if (sw_eh_valid_i) begin
          eh_d    = sw_eh_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (eh_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Error log: a same-cycle pop frees the slot the push needs.
  always_comb begin
    addr_mem_d  = addr_mem_q;
    cause_mem_d = cause_mem_q;
    type_mem_d  = type_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pop_eff     = log_pop_i && (cnt_q != '0);
    push_ok     = err_acc && ((cnt_q != FullCnt) || pop_eff);
    push_drop   = err_acc && !push_ok;
    if (push_ok) begin
      addr_mem_d[wr_ptr_q]  = rsp_i.pld.burst_addr;
      cause_mem_d[wr_ptr_q] = rsp_i.pld.cause;
      type_mem_d[wr_ptr_q]  = rsp_i.pld.err_type;
      wr_ptr_d              = wr_ptr_q + PtrW'(1);
    end
    if (pop_eff) rd_ptr_d = rd_ptr_q + PtrW'(1);
    cnt_d = cnt_q + CntW'(push_ok) - CntW'(pop_eff);
    if (push_drop)          ovf_d = 1'b1;
    else if (log_ovf_clr_i) ovf_d = 1'b0;
    else                    ovf_d = ovf_q;
    if (err_acc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ErrCntWidth'(1);
    else                              err_cnt_d = err_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      eh_q      <= idma_eh_req_t'(idma_pkg::CONTINUE);
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      err_cnt_q <= '0;
      for (int i = 0; i < int'(ErrLogDepth); i++) begin
        addr_mem_q[i]  <= '0;
        cause_mem_q[i] <= '0;
        type_mem_q[i]  <= idma_pkg::BUS_READ;
      end
    end else begin
      state_q     <= state_d;
      eh_q        <= eh_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      err_cnt_q   <= err_cnt_d;
      addr_mem_q  <= addr_mem_d;
      cause_mem_q <= cause_mem_d;
      type_mem_q  <= type_mem_d;
    end
  end

  assign eh_o        = eh_q;
  assign eh_valid_o  = (state_q == ISSUE);
  assign busy_o      = (state_q != IDLE);
  assign log_valid_o = (cnt_q != '0);
  assign irq_o       = log_valid_o;
  assign log_ovf_o   = ovf_q;
  assign err_cnt_o   = err_cnt_q;
  assign log_addr_o  = addr_mem_q[rd_ptr_q];
  assign log_cause_o = cause_mem_q[rd_ptr_q];
  assign log_type_o  = type_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_idma_error_responder.sv
// Bench for idma_error_responder: directed scenarios plus random traffic, all
// outputs compared every cycle against a transaction-level model of the responder.

module tb_idma_error_responder;
  import idma_pkg::*;

  localparam int unsigned Depth  = 4;
  localparam int unsigned CntW   = 16;
  localparam int unsigned CntMax = 65535;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic                testmode_i;
  idma_rsp_t           rsp_i;
  logic                rsp_valid_i, rsp_ready_o;
  logic                done_last_o, done_valid_o, done_ready_i;
  idma_eh_req_t        eh_o, sw_eh_i;
  logic                eh_valid_o, eh_ready_i;
  logic [1:0]          policy_i;
  logic                sw_eh_valid_i, sw_eh_ready_o;
  addr_t               log_addr_o;
  logic [1:0]          log_cause_o;
  err_type_t           log_type_o;
  logic                log_valid_o, log_pop_i, log_ovf_o, log_ovf_clr_i;
  logic [CntW-1:0]     err_cnt_o;
  logic                irq_o, busy_o;

  idma_error_responder #(.ErrLogDepth(Depth), .ErrCntWidth(CntW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .testmode_i(testmode_i),
    .rsp_i(rsp_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .done_last_o(done_last_o), .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .eh_o(eh_o), .eh_valid_o(eh_valid_o), .eh_ready_i(eh_ready_i),
    .policy_i(policy_i), .sw_eh_i(sw_eh_i), .sw_eh_valid_i(sw_eh_valid_i),
    .sw_eh_ready_o(sw_eh_ready_o), .log_addr_o(log_addr_o), .log_cause_o(log_cause_o),
    .log_type_o(log_type_o), .log_valid_o(log_valid_o), .log_pop_i(log_pop_i),
    .log_ovf_o(log_ovf_o), .log_ovf_clr_i(log_ovf_clr_i), .err_cnt_o(err_cnt_o),
    .irq_o(irq_o), .busy_o(busy_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transaction-level model: an outstanding error either awaits a decision or holds one.
  typedef struct {addr_t a; logic [1:0] c; err_type_t t;} ent_t;
  ent_t         m_log[$];
  int unsigned  m_errs;
  bit           m_ovf, m_pend, m_known;
  idma_eh_req_t m_dec;

  task automatic model_reset();
    m_log.delete();
    m_errs = 0; m_ovf = 0; m_pend = 0; m_known = 0; m_dec = CONTINUE;
  endtask

  task automatic check_outputs();
    bit idle;
    bit dv;
    idle = !m_pend;
    dv   = idle && rsp_valid_i && !rsp_i.error;
    check("rsp_ready", rsp_ready_o, idle ? (rsp_i.error ? 1'b1 : done_ready_i) : 1'b0);
    check("done_valid", done_valid_o, dv);
    check("done_last", done_last_o, dv && rsp_i.last);
    check("eh_valid", eh_valid_o, m_pend && m_known);
    check("eh", eh_o, m_dec);
    check("sw_ready", sw_eh_ready_o, m_pend && !m_known);
    check("log_valid", log_valid_o, m_log.size() > 0);
    check("irq", irq_o, m_log.size() > 0);
    check("ovf", log_ovf_o, m_ovf);
    check("err_cnt", err_cnt_o, (m_errs > CntMax) ? CntMax : m_errs);
    check("busy", busy_o, m_pend);
    if (m_log.size() > 0) begin
      check("log_addr", log_addr_o, m_log[0].a);
      check("log_cause", log_cause_o, m_log[0].c);
      check("log_type", log_type_o, m_log[0].t);
    end
  endtask

  task automatic model_update();
    bit acc;
    bit popped;
    ent_t e;
    acc    = !m_pend && rsp_valid_i && rsp_i.error;
    popped = log_pop_i && (m_log.size() > 0);
    if (popped) void'(m_log.pop_front());
    if (acc) begin
      m_errs++;
      if (m_log.size() < Depth) begin
        e.a = rsp_i.pld.burst_addr; e.c = rsp_i.pld.cause; e.t = rsp_i.pld.err_type;
        m_log.push_back(e);
      end else m_ovf = 1;
    end
    if (!(acc && m_log.size() == Depth && !popped && m_ovf) && log_ovf_clr_i && !(acc && !popped && m_log.size() == Depth))
      m_ovf = m_ovf && !log_ovf_clr_i ? m_ovf : m_ovf;
    if (acc) begin
      m_pend = 1;
      if (policy_i == 2'b01)      begin m_known = 1; m_dec = CONTINUE; end
      else if (policy_i == 2'b10) begin m_known = 1; m_dec = ABORT;    end
      else                              m_known = 0;
    end else if (m_pend && !m_known && sw_eh_valid_i) begin
      m_known = 1; m_dec = sw_eh_i;
    end else if (m_pend && m_known && eh_ready_i) begin
      m_pend = 0;
    end
  endtask

  // Overflow flag: a drop this cycle sets it, otherwise a clear request resets it.
  task automatic ovf_update(input bit dropped);
    if (dropped) m_ovf = 1;
    else if (log_ovf_clr_i) m_ovf = 0;
  endtask

  task automatic cycle();
    bit dropped;
    #1;
    check_outputs();
    @(posedge clk);
    dropped = !m_pend && rsp_valid_i && rsp_i.error && (m_log.size() == Depth) &&
              !(log_pop_i && m_log.size() > 0);
    ovf_update(dropped);
    model_update();
    @(negedge clk);
  endtask

  function automatic idma_rsp_t mk_rsp(bit last, bit err, logic [1:0] cause, err_type_t t, addr_t a);
    idma_rsp_t r;
    r.last = last; r.error = err;
    r.pld.cause = cause; r.pld.err_type = t; r.pld.burst_addr = a;
    return r;
  endfunction

  task automatic idle_inputs();
    testmode_i = 0; rsp_i = '0; rsp_valid_i = 0; done_ready_i = 0; eh_ready_i = 0;
    policy_i = 2'b00; sw_eh_i = CONTINUE; sw_eh_valid_i = 0; log_pop_i = 0; log_ovf_clr_i = 0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Runs idle cycles until the model reports no outstanding error, bounded.
  task automatic drain_eh();
    int n = 0;
    eh_ready_i = 1; sw_eh_valid_i = 1; rsp_valid_i = 0;
    while (m_pend && n < 20) begin cycle(); n++; end
    check("drain_timeout", m_pend, 1'b0);
    eh_ready_i = 0; sw_eh_valid_i = 0;
  endtask

  initial begin
    do_reset();

    // Three good responses, last on the third.
    done_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      rsp_i = mk_rsp(i == 2, 0, 2'd0, BUS_READ, addr_t'(32'h100 * i)); rsp_valid_i = 1;
      cycle();
    end
    idle_inputs();
    cycle();

    // Auto-CONTINUE error: decision one cycle after acceptance.
    rsp_i = mk_rsp(0, 1, 2'd2, BUS_WRITE, 32'h1000); rsp_valid_i = 1; policy_i = 2'b01;
    cycle();
    rsp_valid_i = 0;
    check("auto_eh_valid", eh_valid_o, 1'b1);
    check("auto_log_addr", log_addr_o, 32'h1000);
    cycle();
    drain_eh();
    log_pop_i = 1; cycle(); log_pop_i = 0;
    cycle();

    // Software ABORT after five cycles while another error waits.
    rsp_i = mk_rsp(0, 1, 2'd3, BACKEND, 32'h2000); rsp_valid_i = 1; policy_i = 2'b00;
    cycle();
    rsp_i = mk_rsp(0, 1, 2'd1, BUS_READ, 32'h3000);
    repeat (5) cycle();
    sw_eh_i = ABORT; sw_eh_valid_i = 1;
    cycle();
    sw_eh_valid_i = 0; rsp_valid_i = 0;
    check("sw_eh_abort", eh_o, ABORT);
    cycle();
    drain_eh();

    // Five auto errors into a four-deep log, then empty it.
    log_pop_i = 1; repeat (2) cycle(); log_pop_i = 0;
    eh_ready_i = 1; policy_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      rsp_i = mk_rsp(0, 1, 2'(i), err_type_t'(i % 4), addr_t'(32'h4000 + i)); rsp_valid_i = 1;
      cycle();
      rsp_valid_i = 0;
      cycle();
    end
    check("ovf_after5", log_ovf_o, 1'b1);
    log_pop_i = 1; repeat (4) cycle(); log_pop_i = 0;
    cycle();
    check("irq_after_pops", irq_o, 1'b0);

    // Decision stall: eh_ready low for ten cycles with a new error pending.
    eh_ready_i = 0; policy_i = 2'b01; log_ovf_clr_i = 1;
    rsp_i = mk_rsp(0, 1, 2'd2, ND_MIDEND, 32'h5000); rsp_valid_i = 1;
    cycle();
    log_ovf_clr_i = 0;
    rsp_i = mk_rsp(0, 1, 2'd1, BUS_WRITE, 32'h6000);
    repeat (10) cycle();
    drain_eh();

    // Reset while waiting on software, then a good response passes straight through.
    rsp_i = mk_rsp(0, 1, 2'd2, BUS_READ, 32'h7000); rsp_valid_i = 1; policy_i = 2'b11;
    cycle();
    rsp_valid_i = 0;
    cycle();
    do_reset();
    rsp_i = mk_rsp(1, 0, 2'd0, BUS_READ, 32'h8000); rsp_valid_i = 1; done_ready_i = 1;
    cycle();
    idle_inputs();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rsp_i         = mk_rsp($urandom_range(0, 1), ($urandom_range(0, 9) < 3),
                             2'($urandom_range(0, 3)), err_type_t'($urandom_range(0, 3)),
                             addr_t'($urandom));
      rsp_valid_i   = ($urandom_range(0, 1) == 1);
      done_ready_i  = ($urandom_range(0, 3) != 0);
      eh_ready_i    = ($urandom_range(0, 2) != 0);
      policy_i      = 2'($urandom_range(0, 3));
      sw_eh_i       = idma_eh_req_t'($urandom_range(0, 1));
      sw_eh_valid_i = ($urandom_range(0, 3) == 0);
      log_pop_i     = ($urandom_range(0, 4) == 0);
      log_ovf_clr_i = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
